rr_decode_arbiter: RTL and testbench



---
 rtl/rr_decode_arbiter.sv | 99 +++++++++
 tb/tb_rr_decode_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for the shared 8-way one-hot select: registered index, decoded one-hot grant.
// Optional forced release after HOLD_MAX cycles when RR_DECODE_ARBITER_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] pick;
  logic       pick_vld;
  logic [2:0] cand;
  logic       owner_drop;
  logic       expire;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX out of range 1..255");
  end

  // Walk from the farthest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    cand     = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_drop = done | ~req[gnt_idx];

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign expire = (hold_cnt + 8'd1 == 8'(HOLD_MAX));

  // Counter sits at zero outside GRANT, so it is clear on every grant entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout  <= (state == GRANT) & expire & ~owner_drop;
      hold_cnt <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_idx <= pick;
            gnt     <= 8'b1 << pick;
            gnt_vld <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (owner_drop | expire) begin
            gnt     <= '0;
            gnt_vld <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          ptr   <= gnt_idx + 3'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboarded random + directed bench for rr_decode_arbiter; grant records come from a
// grant-level reference model and are matched by an independent output monitor.
module tb_rr_decode_arbiter;
  localparam int HM = 4;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  rr_decode_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int start;
    int len;
    bit to;
  } grant_t;

  grant_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model: who owns the resource, for how long, and where the search starts next.
  int  m_phase = 0;   // 0 free, 1 owned, 2 release cycle
  int  m_ptr = 0;
  int  m_owner = 0;
  int  m_hold = 0;
  int  m_start = 0;

  function automatic int first_from(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_edge(input int edge_no);
    grant_t g;
    case (m_phase)
      0: if (req != 0) begin
        m_owner = first_from(req, m_ptr);
        m_hold  = 0;
        m_start = edge_no;
        m_phase = 1;
      end
      1: begin
        m_hold++;
        if (done || !req[m_owner] || (TO_EN && m_hold == HM)) begin
          g.idx = m_owner; g.start = m_start; g.len = m_hold;
          g.to  = !(done || !req[m_owner]);
          sb.push_back(g);
          m_phase = 2;
        end
      end
      default: begin
        m_ptr   = (m_owner + 1) % 8;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    model_edge(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_vld", gnt_vld, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_timeout", timeout, 0);
    m_phase = 0; m_ptr = 0; m_owner = 0; m_hold = 0;
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // Monitor: rebuilds each grant from the outputs and matches it against the scoreboard.
  initial begin
    bit in_grant = 0;
    int r_start = 0;
    int r_idx = 0;
    grant_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_grant = 0;
      end else if (!in_grant && gnt_vld) begin
        in_grant = 1;
        r_start  = cyc;
        r_idx    = gnt_idx;
      end else if (in_grant && !gnt_vld) begin
        in_grant = 0;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_idx", r_idx, e.idx);
          chk("sb_start", r_start, e.start);
          chk("sb_len", cyc - r_start, e.len);
          chk("sb_timeout", timeout, e.to);
        end
      end
      if (!rst) begin
        if (gnt_vld) chk("gnt_decode", gnt, 8'd1 << gnt_idx);
        else         chk("gnt_zero", gnt, 0);
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] prev_r;
    #12;
    chk("init_gnt", gnt, 0);
    chk("init_vld", gnt_vld, 0);
    @(negedge clk);
    rst = 1'b0;
    do_reset();

    // single requester
    step(8'h01, 0);
    chk("single_gnt", gnt, 8'h01);
    chk("single_idx", gnt_idx, 0);
    step(8'h01, 1);
    chk("single_rel_gnt", gnt, 0);
    chk("single_rel_vld", gnt_vld, 0);
    step(8'h00, 0);
    step(8'hFF, 0);
    chk("single_ptr1", gnt_idx, 1);

    // fairness and wrap
    do_reset();
    step(8'hFF, 0);
    for (int i = 0; i < 9; i++) begin
      chk("fair_idx", gnt_idx, i % 8);
      chk("fair_vld", gnt_vld, 1);
      step(8'hFF, 1);
      step(8'hFF, 0);
      chk("fair_gap", gnt_vld, 0);
      step(8'hFF, 0);
    end

    // rotation search after grant to 4
    step(8'hFF, 1);
    step(8'h00, 0);
    step(8'h00, 0);
    step(8'h10, 0);
    chk("rot_idx4", gnt_idx, 4);
    step(8'h10, 1);
    step(8'h00, 0);
    step(8'h12, 0);
    chk("rot_idx", gnt_idx, 1);
    chk("rot_gnt", gnt, 8'h02);
    chk("rot_vld", gnt_vld, 1);

    // reset mid-grant
    step(8'h12, 1);
    step(8'h00, 0);
    step(8'h00, 0);
    step(8'h20, 0);
    chk("midrst_pre", gnt, 8'h20);
    do_reset();
    step(8'hFF, 0);
    chk("midrst_first", gnt_idx, 0);

    // hold behaviour with a lone persistent requester
    step(8'hFF, 1);
    step(8'h00, 0);
    step(8'h00, 0);
    step(8'h08, 0);
    chk("hold_gnt", gnt, 8'h08);
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    for (int i = 0; i < HM - 1; i++) begin
      step(8'h08, 0);
      chk("to_hold", gnt, 8'h08);
    end
    step(8'h08, 0);
    chk("to_rel_gnt", gnt, 0);
    chk("to_pulse", timeout, 1);
    step(8'h08, 0);
    chk("to_pulse_end", timeout, 0);
    step(8'h08, 0);
    chk("to_regrant", gnt_idx, 3);
    chk("to_regrant_vld", gnt_vld, 1);
    for (int i = 0; i < HM - 1; i++) step(8'h08, 0);
    step(8'h08, 1);
    chk("to_done_gnt", gnt, 0);
    chk("to_done_nopulse", timeout, 0);
    step(8'h00, 0);
    chk("to_done_nopulse2", timeout, 0);
`else
    for (int i = 0; i < 20; i++) step(8'h08, 0);
    chk("nolimit_gnt", gnt, 8'h08);
    chk("nolimit_to", timeout, 0);
    step(8'h08, 1);
    chk("nolimit_rel", gnt, 0);
    step(8'h00, 0);
`endif

    // random traffic
    prev_r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) r = prev_r;
      else if ($urandom_range(0, 4) == 0) r = 8'h00;
      else r = 8'($urandom);
      prev_r = r;
      step(r, ($urandom_range(0, 5) == 0));
    end

    // drain
    for (int i = 0; i < 6; i++) step(8'h00, 0);
    chk("drain_vld", gnt_vld, 0);
    chk("drain_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
